// File: rtl/cskipa_stream_accumulator.sv
// -----------------------------------------------------------------------------
// cskipa_stream_accumulator
//
// Sums the beats of each input frame with a carry-skip adder and presents
// one result per frame.
// Frames arrive on a valid/ready stream and are delimited by i_last.
// The running total and each incoming beat feed a purely combinational
// carry-skip adder (cskipa_adder).
// The frame total, a sticky overflow flag and a saturating beat count are
// registered onto a valid/ready result port.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous reset, active-high
//   i_valid  input beat valid
//   o_ready  input beat accepted when i_valid && o_ready
//   i_data   unsigned operand, WIDTH bits
//   i_last   final beat of the frame
//   o_valid  frame result valid
//   i_ready  downstream accepts the result when o_valid && i_ready
//   o_sum    frame total modulo 2^WIDTH
//   o_ovf    a carry-out occurred somewhere in the frame
//   o_count  beats in the frame, saturating at 2^CNT_W-1
//
// cskipa_adder: WIDTH-bit carry-skip adder built from 4-bit ripple blocks.
//   i_add_term1, i_add_term2  operands
//   o_add_sum                 sum modulo 2^WIDTH
//   o_add_cout                carry out of the top bit
// -----------------------------------------------------------------------------

module cskipa_adder #(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  output logic [WIDTH-1:0] o_add_sum,
  output logic             o_add_cout
);

  localparam int NBLK = WIDTH / 4;

  if ((WIDTH % 4) != 0) begin : g_bad_width
    $error("cskipa_adder: WIDTH must be a multiple of 4");
  end

  logic carry_blk;
  logic carry;
  logic prop;
  logic blk_prop;

  // Blocks are walked in order inside one process. Each block ripples its
  // four bits; when every bit of a block propagates, the block's carry-in
  // skips straight to its carry-out.
  // NOTE: the temporaries here are blocking on purpose. Each loop step must
  // see the carry produced by the step before it. Every variable gets a
  // value before use, so no latch is inferred.
  always_comb begin
    o_add_sum = '0;
    carry_blk = 1'b0;
    carry     = 1'b0;
    prop      = 1'b0;
    blk_prop  = 1'b1;
    for (int blk = 0; blk < NBLK; blk++) begin
      blk_prop = 1'b1;
      carry    = carry_blk;
      for (int k = 0; k < 4; k++) begin
        prop                  = i_add_term1[blk*4+k] ^ i_add_term2[blk*4+k];
        o_add_sum[blk*4+k]    = prop ^ carry;
        carry                 = (i_add_term1[blk*4+k] & i_add_term2[blk*4+k]) | (prop & carry);
        blk_prop              = blk_prop & prop;
      end
      carry_blk = blk_prop ? carry_blk : carry;
    end
    o_add_cout = carry_blk;
  end

endmodule

module cskipa_stream_accumulator #(
  parameter int WIDTH = 20,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf,
  output logic [CNT_W-1:0] o_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             valid_q,   valid_d;
  logic [WIDTH-1:0] sum_q,     sum_d;
  logic             ovf_q,     ovf_d;
  logic [CNT_W-1:0] count_q,   count_d;

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  // acc is zero in IDLE and HOLD because it is cleared on every last beat.
  // A beat taken in those states therefore starts a fresh frame with no
  // extra muxing.
  cskipa_adder #(.WIDTH(WIDTH)) u_adder (
    .i_add_term1 (acc_q),
    .i_add_term2 (i_data),
    .o_add_sum   (add_sum),
    .o_add_cout  (add_cout)
  );

  assign o_ready = (state_q != ST_HOLD) || i_ready;
  assign accept  = i_valid && o_ready;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  assign o_valid = valid_q;
  assign o_sum   = sum_q;
  assign o_ovf   = ovf_q;
  assign o_count = count_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_acc_d = ovf_acc_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    count_d   = count_q;

    // The result is consumed first. A beat accepted in the same cycle
    // overrides the state below, so no bubble appears between frames.
    if (state_q == ST_HOLD && i_ready) begin
      valid_d = 1'b0;
      state_d = ST_IDLE;
    end

    if (accept) begin
      if (i_last) begin
        sum_d     = add_sum;
        ovf_d     = ovf_acc_q | add_cout;
        count_d   = cnt_inc;
        valid_d   = 1'b1;
        state_d   = ST_HOLD;
        acc_d     = '0;
        ovf_acc_d = 1'b0;
        cnt_d     = '0;
      end else begin
        acc_d     = add_sum;
        ovf_acc_d = ovf_acc_q | add_cout;
        cnt_d     = cnt_inc;
        state_d   = ST_ACCUM;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments. Every flop then
  // samples values from before the edge, whatever order the statements run in.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ovf_acc_q <= ovf_acc_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_cskipa_stream_accumulator.sv
// -----------------------------------------------------------------------------
// Testbench for cskipa_stream_accumulator (WIDTH=20, CNT_W=8).
// Directed vectors, multi-cycle corner sequences, then random traffic
// compared against a frame-level arithmetic model.
// -----------------------------------------------------------------------------
module tb_cskipa_stream_accumulator;

  localparam int WIDTH = 20;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  int checks = 0;
  int errors = 0;

  cskipa_stream_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (in_data),
    .i_last  (in_last),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_sum   (out_sum),
    .o_ovf   (out_ovf),
    .o_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock. Outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the inputs for the coming edge and let combinational logic settle.
  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #1;
  endtask

  task automatic check_result(input string tag, input logic v, input logic [WIDTH-1:0] s,
                              input logic o, input logic [CNT_W-1:0] c);
    check({tag, ".o_valid"}, 64'(out_valid), 64'(v));
    if (v) begin
      check({tag, ".o_sum"},   64'(out_sum),   64'(s));
      check({tag, ".o_ovf"},   64'(out_ovf),   64'(o));
      check({tag, ".o_count"}, 64'(out_count), 64'(c));
    end
  endtask

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             l;
    logic             r;
    logic             exp_ready;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_ovf;
    logic [CNT_W-1:0] exp_count;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  // Frame-level reference model state used by the random phase.
  longint           m_total;
  int               m_len;
  logic             m_valid;
  logic [WIDTH-1:0] m_sum;
  logic             m_ovf;
  logic [CNT_W-1:0] m_count;

  initial begin
    // Fields: v, d, l, r | ready before the edge | valid, sum, ovf, count after the edge.
    // Frame 1,2,3 with the last flag on 3.
    vecs[0]  = '{1'b1, 20'd1,       1'b0, 1'b1, 1'b1, 1'b0, 20'd0,  1'b0, 8'd0};
    vecs[1]  = '{1'b1, 20'd2,       1'b0, 1'b1, 1'b1, 1'b0, 20'd0,  1'b0, 8'd0};
    vecs[2]  = '{1'b1, 20'd3,       1'b1, 1'b1, 1'b1, 1'b1, 20'd6,  1'b0, 8'd3};
    vecs[3]  = '{1'b0, 20'd0,       1'b0, 1'b1, 1'b1, 1'b0, 20'd0,  1'b0, 8'd0};
    // Overflow frame, followed at once by a one-beat frame (sticky flag cleared).
    vecs[4]  = '{1'b1, 20'hFFFFF,   1'b0, 1'b1, 1'b1, 1'b0, 20'd0,  1'b0, 8'd0};
    vecs[5]  = '{1'b1, 20'h00002,   1'b1, 1'b1, 1'b1, 1'b1, 20'd1,  1'b1, 8'd2};
    vecs[6]  = '{1'b1, 20'd5,       1'b1, 1'b1, 1'b1, 1'b1, 20'd5,  1'b0, 8'd1};
    vecs[7]  = '{1'b0, 20'd0,       1'b0, 1'b1, 1'b1, 1'b0, 20'd0,  1'b0, 8'd0};
    // Backpressure: 10 + 20, result held for four cycles while beats are offered.
    vecs[8]  = '{1'b1, 20'd10,      1'b0, 1'b0, 1'b1, 1'b0, 20'd0,  1'b0, 8'd0};
    vecs[9]  = '{1'b1, 20'd20,      1'b1, 1'b0, 1'b1, 1'b1, 20'd30, 1'b0, 8'd2};
    vecs[10] = '{1'b1, 20'd99,      1'b1, 1'b0, 1'b0, 1'b1, 20'd30, 1'b0, 8'd2};
    vecs[11] = '{1'b1, 20'd98,      1'b0, 1'b0, 1'b0, 1'b1, 20'd30, 1'b0, 8'd2};
    vecs[12] = '{1'b1, 20'd97,      1'b1, 1'b0, 1'b0, 1'b1, 20'd30, 1'b0, 8'd2};
    vecs[13] = '{1'b1, 20'd96,      1'b0, 1'b0, 1'b0, 1'b1, 20'd30, 1'b0, 8'd2};
    vecs[14] = '{1'b0, 20'd0,       1'b0, 1'b1, 1'b1, 1'b0, 20'd0,  1'b0, 8'd0};
    // Back-to-back single-beat frames of 7 with no idle cycle between them.
    vecs[15] = '{1'b1, 20'd7,       1'b1, 1'b1, 1'b1, 1'b1, 20'd7,  1'b0, 8'd1};
    vecs[16] = '{1'b1, 20'd7,       1'b1, 1'b1, 1'b1, 1'b1, 20'd7,  1'b0, 8'd1};
    vecs[17] = '{1'b0, 20'd0,       1'b0, 1'b1, 1'b1, 1'b0, 20'd0,  1'b0, 8'd0};

    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    check("reset.o_valid", 64'(out_valid), 64'd0);
    check("reset.o_sum",   64'(out_sum),   64'd0);
    check("reset.o_ovf",   64'(out_ovf),   64'd0);
    check("reset.o_count", 64'(out_count), 64'd0);
    rst = 1'b0;
    #1;
    check("reset.o_ready", 64'(in_ready), 64'd1);

    // Table-driven vectors.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r);
      check($sformatf("vec%0d.o_ready", i), 64'(in_ready), 64'(vecs[i].exp_ready));
      tick();
      check_result($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_sum,
                   vecs[i].exp_ovf, vecs[i].exp_count);
    end

    // Count saturation: 300 beats of 1.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 20'd1, (i == 299), 1'b1);
      tick();
      if (i < 299 && out_valid) check("sat.early_valid", 64'(out_valid), 64'd0);
    end
    check_result("sat", 1'b1, 20'd300, 1'b0, 8'd255);
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    check("sat.drain", 64'(out_valid), 64'd0);

    // Reset mid-frame discards the partial frame.
    drive(1'b1, 20'd100, 1'b0, 1'b1);
    tick();
    drive(1'b1, 20'd200, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    check("midrst.o_valid", 64'(out_valid), 64'd0);
    check("midrst.o_ready", 64'(in_ready),  64'd1);
    drive(1'b1, 20'd4, 1'b1, 1'b1);
    tick();
    check_result("midrst", 1'b1, 20'd4, 1'b0, 8'd1);

    // Reset during HOLD drops the pending result.
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("holdrst.o_valid", 64'(out_valid), 64'd0);
    check("holdrst.o_sum",   64'(out_sum),   64'd0);

    // Random traffic against the frame-level model.
    m_total = 0;
    m_len   = 0;
    m_valid = 1'b0;
    m_sum   = '0;
    m_ovf   = 1'b0;
    m_count = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic             v, l, r, exp_rdy;
      logic [31:0]      rnd;
      logic [WIDTH-1:0] d;
      rnd = $urandom;
      if ($urandom_range(0, 3) == 0) d = 20'hFFFFF - WIDTH'($urandom_range(0, 15));
      else d = rnd[WIDTH-1:0];
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) < 6);
      drive(v, d, l, r);
      exp_rdy = !m_valid || r;
      check("rand.o_ready", 64'(in_ready), 64'(exp_rdy));
      // Model update for this edge.
      if (m_valid && r) m_valid = 1'b0;
      if (v && exp_rdy) begin
        m_total += longint'(d);
        m_len++;
        if (l) begin
          m_sum   = m_total[WIDTH-1:0];
          m_ovf   = (m_total >= (longint'(1) << WIDTH));
          m_count = (m_len > 255) ? 8'd255 : CNT_W'(m_len);
          m_valid = 1'b1;
          m_total = 0;
          m_len   = 0;
        end
      end
      tick();
      check_result("rand", m_valid, m_sum, m_ovf, m_count);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
